// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: each channel counts 0..P and drives
// clockdivided high while count < H, with glitch-free reloads at period boundaries.
module clock_divider_multi #(
    parameter int WIDTH          = 16,
    parameter int CHANNELS       = 2,
    parameter int DEFAULT_PERIOD = 390,
    parameter int DEFAULT_HIGH   = 195,
    localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                load,
    input  logic [CW-1:0]       load_chan,
    input  logic [WIDTH-1:0]    load_period,
    input  logic [WIDTH-1:0]    load_high,
    output logic [CHANNELS-1:0] clockdivided,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [WIDTH-1:0] RST_P = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] RST_H = WIDTH'(DEFAULT_HIGH);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    // load is a single-cycle strobe with no ready: it is always accepted on the
    // edge where it is high; a load_chan with no matching channel is dropped.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] act_p;
        logic [WIDTH-1:0] act_h;
        logic [WIDTH-1:0] shd_p;
        logic [WIDTH-1:0] shd_h;
        logic             shd_valid;
        logic             run;
        logic             hit;
        logic             wrap;

        assign hit  = load && (load_chan == CW'(c));
        assign wrap = (count == act_p);

        always_ff @(posedge clock) begin
            if (reset) begin
                count     <= '0;
                run       <= 1'b0;
                shd_valid <= 1'b0;
                act_p     <= RST_P;
                act_h     <= RST_H;
                shd_p     <= RST_P;
                shd_h     <= RST_H;
            end else begin
                run <= enable[c];
                if (!enable[c]) begin
                    // A stopped channel has no boundary to wait for: apply now.
                    count <= '0;
                    if (hit) begin
                        act_p     <= load_period;
                        act_h     <= load_high;
                        shd_valid <= 1'b0;
                    end else if (shd_valid) begin
                        act_p     <= shd_p;
                        act_h     <= shd_h;
                        shd_valid <= 1'b0;
                    end
                end else if (!run) begin
                    count <= '0;
                    if (hit) begin
                        shd_p     <= load_period;
                        shd_h     <= load_high;
                        shd_valid <= 1'b1;
                    end
                end else if (wrap) begin
                    // A load landing on the wrap edge bypasses the shadow entirely.
                    count <= '0;
                    if (hit) begin
                        act_p <= load_period;
                        act_h <= load_high;
                    end else if (shd_valid) begin
                        act_p <= shd_p;
                        act_h <= shd_h;
                    end
                    shd_valid <= 1'b0;
                end else begin
                    count <= count + ONE;
                    if (hit) begin
                        shd_p     <= load_period;
                        shd_h     <= load_high;
                        shd_valid <= 1'b1;
                    end
                end
            end
        end

        assign clockdivided[c] = run && (count < act_h);
        assign tick[c]         = run && wrap;
        assign pending[c]      = shd_valid;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: three channels so that an out-of-range
// load_chan is representable on the 2-bit select.
module tb_clock_divider_multi;

    logic        clock;
    logic        reset;
    logic [2:0]  enable;
    logic        load;
    logic [1:0]  load_chan;
    logic [15:0] load_period;
    logic [15:0] load_high;
    logic [2:0]  clockdivided;
    logic [2:0]  tick;
    logic [2:0]  pending;

    int tests;
    int fails;

    clock_divider_multi #(
        .WIDTH(16), .CHANNELS(3), .DEFAULT_PERIOD(390), .DEFAULT_HIGH(195)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .load_chan(load_chan), .load_period(load_period), .load_high(load_high),
        .clockdivided(clockdivided), .tick(tick), .pending(pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [1:0] ch, input logic [15:0] p, input logic [15:0] h);
        load = 1'b1; load_chan = ch; load_period = p; load_high = h;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 3'b000; load = 1'b0;
        load_chan = 2'd0; load_period = 16'd0; load_high = 16'd0;
        step(); step();
        tests++; if (clockdivided !== 3'b000) begin fails++; $display("FAIL reset_cd got=%b exp=000", clockdivided); end
        tests++; if (tick !== 3'b000) begin fails++; $display("FAIL reset_tick got=%b exp=000", tick); end
        tests++; if (pending !== 3'b000) begin fails++; $display("FAIL reset_pending got=%b exp=000", pending); end
        reset = 1'b0;
        step();
        tests++; if ({clockdivided, tick} !== 6'b0) begin fails++; $display("FAIL idle_outputs got=%b/%b exp=0/0", clockdivided, tick); end
    endtask

    task automatic test_default();
        enable = 3'b001;
        step();
        for (int i = 0; i < 391; i++) begin
            tests++; if (clockdivided[0] !== (i < 195)) begin fails++; $display("FAIL default_cd i=%0d got=%b exp=%b", i, clockdivided[0], (i < 195)); end
            tests++; if (tick[0] !== (i == 390)) begin fails++; $display("FAIL default_tick i=%0d got=%b exp=%b", i, tick[0], (i == 390)); end
            step();
        end
        tests++; if ({clockdivided[0], tick[0]} !== 2'b10) begin fails++; $display("FAIL default_rewrap got=%b%b exp=10", clockdivided[0], tick[0]); end
    endtask

    task automatic test_reload();
        repeat (100) step();
        do_load(2'd0, 16'd9, 16'd3);
        tests++; if (pending[0] !== 1'b1) begin fails++; $display("FAIL reload_pending got=%b exp=1", pending[0]); end
        repeat (289) step();
        tests++; if ({tick[0], clockdivided[0], pending[0]} !== 3'b101) begin fails++; $display("FAIL reload_at_wrap got=%b exp=101", {tick[0], clockdivided[0], pending[0]}); end
        step();
        for (int j = 0; j < 20; j++) begin
            tests++; if (clockdivided[0] !== ((j % 10) < 3)) begin fails++; $display("FAIL reload_cd j=%0d got=%b exp=%b", j, clockdivided[0], ((j % 10) < 3)); end
            tests++; if (tick[0] !== ((j % 10) == 9)) begin fails++; $display("FAIL reload_tick j=%0d got=%b exp=%b", j, tick[0], ((j % 10) == 9)); end
            tests++; if (pending[0] !== 1'b0) begin fails++; $display("FAIL reload_pend_clr j=%0d got=%b exp=0", j, pending[0]); end
            step();
        end
    endtask

    task automatic test_collision();
        do_load(2'd1, 16'd7, 16'd4);
        tests++; if (pending[1] !== 1'b0) begin fails++; $display("FAIL coll_setup_pend got=%b exp=0", pending[1]); end
        enable = enable | 3'b010;
        step();
        tests++; if (tick[1] !== 1'b0) begin fails++; $display("FAIL coll_start_tick got=%b exp=0", tick[1]); end
        repeat (7) step();
        tests++; if (tick[1] !== 1'b1) begin fails++; $display("FAIL coll_wrap_tick got=%b exp=1", tick[1]); end
        do_load(2'd1, 16'd4, 16'd2);
        for (int j = 0; j < 10; j++) begin
            tests++; if (clockdivided[1] !== ((j % 5) < 2)) begin fails++; $display("FAIL coll_cd j=%0d got=%b exp=%b", j, clockdivided[1], ((j % 5) < 2)); end
            tests++; if (tick[1] !== ((j % 5) == 4)) begin fails++; $display("FAIL coll_tick j=%0d got=%b exp=%b", j, tick[1], ((j % 5) == 4)); end
            tests++; if (pending[1] !== 1'b0) begin fails++; $display("FAIL coll_pend j=%0d got=%b exp=0", j, pending[1]); end
            step();
        end
    endtask

    task automatic test_edges();
        enable[0] = 1'b0;
        do_load(2'd0, 16'd0, 16'd1);
        tests++; if ({clockdivided[0], pending[0]} !== 2'b00) begin fails++; $display("FAIL edge_disabled got=%b%b exp=00", clockdivided[0], pending[0]); end
        enable[0] = 1'b1;
        step();
        for (int j = 0; j < 5; j++) begin
            tests++; if ({clockdivided[0], tick[0]} !== 2'b11) begin fails++; $display("FAIL edge_p0_h1 j=%0d got=%b%b exp=11", j, clockdivided[0], tick[0]); end
            step();
        end
        do_load(2'd0, 16'd0, 16'd0);
        for (int j = 0; j < 4; j++) begin
            tests++; if ({clockdivided[0], tick[0], pending[0]} !== 3'b010) begin fails++; $display("FAIL edge_h0 j=%0d got=%b exp=010", j, {clockdivided[0], tick[0], pending[0]}); end
            step();
        end
        do_load(2'd0, 16'd9, 16'd20);
        for (int j = 0; j < 12; j++) begin
            tests++; if (clockdivided[0] !== 1'b1) begin fails++; $display("FAIL edge_h_gt_p_cd j=%0d got=%b exp=1", j, clockdivided[0]); end
            tests++; if (tick[0] !== ((j % 10) == 9)) begin fails++; $display("FAIL edge_h_gt_p_tick j=%0d got=%b exp=%b", j, tick[0], ((j % 10) == 9)); end
            step();
        end
    endtask

    task automatic test_enable_reset();
        enable[0] = 1'b0;
        do_load(2'd0, 16'd99, 16'd60);
        enable[0] = 1'b1;
        step();
        repeat (50) step();
        tests++; if (clockdivided[0] !== 1'b1) begin fails++; $display("FAIL en_count50_cd got=%b exp=1", clockdivided[0]); end
        enable[0] = 1'b0;
        step();
        tests++; if ({clockdivided[0], tick[0]} !== 2'b00) begin fails++; $display("FAIL en_drop got=%b%b exp=00", clockdivided[0], tick[0]); end
        do_load(2'd0, 16'd9, 16'd3);
        tests++; if (pending[0] !== 1'b0) begin fails++; $display("FAIL en_load_disabled_pend got=%b exp=0", pending[0]); end
        enable[0] = 1'b1;
        step();
        for (int j = 0; j < 10; j++) begin
            tests++; if (clockdivided[0] !== (j < 3)) begin fails++; $display("FAIL en_restart_cd j=%0d got=%b exp=%b", j, clockdivided[0], (j < 3)); end
            tests++; if (tick[0] !== (j == 9)) begin fails++; $display("FAIL en_restart_tick j=%0d got=%b exp=%b", j, tick[0], (j == 9)); end
            step();
        end
        do_load(2'd0, 16'd5, 16'd1);
        tests++; if (pending[0] !== 1'b1) begin fails++; $display("FAIL rst_pre_pend got=%b exp=1", pending[0]); end
        reset = 1'b1;
        step();
        tests++; if (pending !== 3'b000) begin fails++; $display("FAIL rst_pend_clear got=%b exp=000", pending); end
        tests++; if ({clockdivided, tick} !== 6'b0) begin fails++; $display("FAIL rst_outputs got=%b/%b exp=0/0", clockdivided, tick); end
        step();
        tests++; if ({clockdivided, tick} !== 6'b0) begin fails++; $display("FAIL rst_held got=%b/%b exp=0/0", clockdivided, tick); end
        reset = 1'b0;
        step();
        for (int i = 0; i < 391; i++) begin
            tests++; if (clockdivided[1:0] !== {2{i < 195}}) begin fails++; $display("FAIL rst_default_cd i=%0d got=%b exp=%b", i, clockdivided[1:0], {2{i < 195}}); end
            tests++; if (tick[1:0] !== {2{i == 390}}) begin fails++; $display("FAIL rst_default_tick i=%0d got=%b exp=%b", i, tick[1:0], {2{i == 390}}); end
            step();
        end
    endtask

    task automatic test_illegal_chan();
        enable = 3'b000;
        step();
        do_load(2'd3, 16'd2, 16'd1);
        tests++; if (pending !== 3'b000) begin fails++; $display("FAIL illegal_pend got=%b exp=000", pending); end
        enable = 3'b111;
        step();
        for (int i = 0; i < 391; i++) begin
            tests++; if (clockdivided !== {3{i < 195}}) begin fails++; $display("FAIL illegal_cd i=%0d got=%b exp=%b", i, clockdivided, {3{i < 195}}); end
            tests++; if (tick !== {3{i == 390}}) begin fails++; $display("FAIL illegal_tick i=%0d got=%b exp=%b", i, tick, {3{i == 390}}); end
            tests++; if (pending !== 3'b000) begin fails++; $display("FAIL illegal_pend_run i=%0d got=%b exp=000", i, pending); end
            step();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_default();
        test_reload();
        test_collision();
        test_edges();
        test_enable_reset();
        test_illegal_chan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
